// File: rtl/vga_rect_fill.sv
// Rectangle-fill engine feeding the VGA pixel port: latches a rectangle on go,
// then walks it in raster order, one pixel per clock, plotting on-screen pixels.
module vga_rect_fill #(
  parameter int X_RES = 160,
  parameter int Y_RES = 120
) (
  input  logic       CLOCK_50,
  input  logic       reset,
  input  logic       go,
  input  logic       clear,
  input  logic [7:0] x0,
  input  logic [6:0] y0,
  input  logic [7:0] w,
  input  logic [6:0] h,
  input  logic [2:0] color,
  output logic [7:0] VGA_X,
  output logic [6:0] VGA_Y,
  output logic [2:0] VGA_COLOR,
  output logic       plot,
  output logic       busy,
  output logic       done
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_DRAW = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  localparam logic [8:0] X_LIM  = 9'(X_RES);
  localparam logic [7:0] Y_LIM  = 8'(Y_RES);
  localparam logic [7:0] CLR_W  = 8'(X_RES);
  localparam logic [6:0] CLR_H  = 7'(Y_RES);

  logic [1:0] state_q, state_d;
  logic [8:0] x_q, x_d;
  logic [7:0] y_q, y_d;
  logic [8:0] x0_q, x0_d;
  logic [8:0] x_end_q, x_end_d;
  logic [7:0] y_end_q, y_end_d;
  logic [2:0] color_q, color_d;
  logic       plot_q, plot_d;
  logic       busy_q, busy_d;
  logic       done_q, done_d;

  logic [7:0] x0_in, w_in;
  logic [6:0] y0_in, h_in;

  always_comb begin
    x0_in = clear ? 8'd0 : x0;
    y0_in = clear ? 7'd0 : y0;
    w_in  = clear ? CLR_W : w;
    h_in  = clear ? CLR_H : h;
  end

  always_comb begin
    state_d = state_q;
    x_d     = x_q;
    y_d     = y_q;
    x0_d    = x0_q;
    x_end_d = x_end_q;
    y_end_d = y_end_q;
    color_d = color_q;
    plot_d  = 1'b0;
    busy_d  = 1'b0;
    done_d  = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (go) begin
          x0_d    = {1'b0, x0_in};
          x_end_d = {1'b0, x0_in} + {1'b0, w_in} - 9'd1;
          y_end_d = {1'b0, y0_in} + {1'b0, h_in} - 8'd1;
          if (w_in == 8'd0 || h_in == 7'd0) begin
            state_d = S_DONE;
            done_d  = 1'b1;
          end else begin
            state_d = S_DRAW;
            x_d     = {1'b0, x0_in};
            y_d     = {1'b0, y0_in};
            color_d = color;
            busy_d  = 1'b1;
            plot_d  = ({1'b0, x0_in} < X_LIM) && ({1'b0, y0_in} < Y_LIM);
          end
        end
      end
      S_DRAW: begin
        if (x_q == x_end_q && y_q == y_end_q) begin
          state_d = S_DONE;
          done_d  = 1'b1;
        end else begin
          // Wrap to the left edge at the end of each row.
          if (x_q == x_end_q) begin
            x_d = x0_q;
            y_d = y_q + 8'd1;
          end else begin
            x_d = x_q + 9'd1;
          end
          busy_d = 1'b1;
          plot_d = (x_d < X_LIM) && (y_d < Y_LIM);
        end
      end
      S_DONE: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      x_q     <= '0;
      y_q     <= '0;
      x0_q    <= '0;
      x_end_q <= '0;
      y_end_q <= '0;
      color_q <= '0;
      plot_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      x_q     <= x_d;
      y_q     <= y_d;
      x0_q    <= x0_d;
      x_end_q <= x_end_d;
      y_end_q <= y_end_d;
      color_q <= color_d;
      plot_q  <= plot_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign VGA_X     = x_q[7:0];
  assign VGA_Y     = y_q[6:0];
  assign VGA_COLOR = color_q;
  assign plot      = plot_q;
  assign busy      = busy_q;
  assign done      = done_q;

endmodule

// File: tb/tb_vga_rect_fill.sv
// Directed and randomized fills checked against a raster-order pixel list
// built from nested loops over the requested rectangle.
module tb_vga_rect_fill;

  logic       clk = 1'b0;
  logic       reset;
  logic       go, clear;
  logic [7:0] x0, w;
  logic [6:0] y0, h;
  logic [2:0] color;
  logic [7:0] VGA_X;
  logic [6:0] VGA_Y;
  logic [2:0] VGA_COLOR;
  logic       plot, busy, done;

  int tests  = 0;
  int failed = 0;

  vga_rect_fill dut (
    .CLOCK_50 (clk),
    .reset    (reset),
    .go       (go),
    .clear    (clear),
    .x0       (x0),
    .y0       (y0),
    .w        (w),
    .h        (h),
    .color    (color),
    .VGA_X    (VGA_X),
    .VGA_Y    (VGA_Y),
    .VGA_COLOR(VGA_COLOR),
    .plot     (plot),
    .busy     (busy),
    .done     (done)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] obs_all();
    return {11'd0, busy, plot, done, VGA_X, VGA_Y, VGA_COLOR};
  endfunction

  function automatic logic [31:0] obs_ctl();
    return {29'd0, busy, plot, done};
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  // Issue one request and follow it cycle by cycle. inj_at: DRAW index at which a
  // competing go is driven; rst_at: DRAW index at which reset aborts the fill.
  task automatic run_fill(input bit clr, input logic [7:0] rx, input logic [6:0] ry,
                          input logic [7:0] rw, input logic [6:0] rh, input logic [2:0] rc,
                          input int inj_at, input int rst_at);
    int px[$];
    int py[$];
    int ex0, ey0, ew, eh, n;
    logic [31:0] exp;
    ex0 = clr ? 0 : int'(rx);
    ey0 = clr ? 0 : int'(ry);
    ew  = clr ? 160 : int'(rw);
    eh  = clr ? 120 : int'(rh);
    for (int yy = ey0; yy < ey0 + eh; yy++)
      for (int xx = ex0; xx < ex0 + ew; xx++) begin
        px.push_back(xx);
        py.push_back(yy);
      end
    n = px.size();

    clear = clr; x0 = rx; y0 = ry; w = rw; h = rh; color = rc; go = 1'b1;
    @(posedge clk);
    @(negedge clk);
    go = 1'b0; clear = 1'b0;
    x0 = 8'($urandom); y0 = 7'($urandom); w = 8'($urandom); h = 7'($urandom);
    color = 3'($urandom);

    if (n == 0) begin
      check("zero_done", obs_ctl(), 32'b001);
      step();
      check("zero_idle", obs_ctl(), 32'b000);
      return;
    end

    for (int i = 0; i < n; i++) begin
      if (i == rst_at) begin
        reset = 1'b1;
        #1;
        check("rst_async", obs_all(), 32'd0);
        step();
        check("rst_held", obs_all(), 32'd0);
        reset = 1'b0;
        step();
        check("rst_nodone", obs_ctl(), 32'b000);
        return;
      end
      if (i == inj_at) begin
        go = 1'b1; clear = 1'b1; color = ~rc;
        x0 = 8'd1; y0 = 7'd1; w = 8'd1; h = 7'd1;
      end
      if (i == inj_at + 1) begin
        go = 1'b0; clear = 1'b0;
      end
      exp = {11'd0, 1'b1, (px[i] < 160 && py[i] < 120), 1'b0,
             8'(px[i]), 7'(py[i]), rc};
      check($sformatf("pix%0d", i), obs_all(), exp);
      step();
    end
    go = 1'b0; clear = 1'b0;
    check("done_pulse", obs_ctl(), 32'b001);
    check("done_hold_xy", {17'd0, VGA_X, VGA_Y}, {17'd0, 8'(px[n-1]), 7'(py[n-1])});
    step();
    check("idle_after", obs_ctl(), 32'b000);
  endtask

  initial begin
    int rx, ry, rw, rh;
    reset = 1'b1; go = 1'b0; clear = 1'b0;
    x0 = '0; y0 = '0; w = '0; h = '0; color = '0;
    #2;
    check("reset_state", obs_all(), 32'd0);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    step();
    check("idle_no_go", obs_ctl(), 32'b000);

    run_fill(1'b0, 8'd3, 7'd4, 8'd2, 7'd2, 3'd5, -1, -1);
    run_fill(1'b0, 8'd20, 7'd20, 8'd0, 7'd10, 3'd1, -1, -1);
    run_fill(1'b0, 8'd20, 7'd20, 8'd5, 7'd0, 3'd1, -1, -1);
    run_fill(1'b0, 8'd158, 7'd118, 8'd4, 7'd4, 3'd2, -1, -1);
    run_fill(1'b1, 8'd50, 7'd60, 8'd3, 7'd3, 3'd7, -1, -1);
    run_fill(1'b0, 8'd10, 7'd10, 8'd10, 7'd10, 3'd4, 5, -1);
    run_fill(1'b0, 8'd10, 7'd10, 8'd10, 7'd10, 3'd6, -1, 30);
    run_fill(1'b0, 8'd7, 7'd7, 8'd1, 7'd1, 3'd3, -1, -1);
    run_fill(1'b0, 8'd250, 7'd125, 8'd255, 7'd3, 3'd1, -1, -1);

    // go held high: fill, one DONE cycle, one IDLE cycle, then the next fill.
    x0 = 8'd1; y0 = 7'd2; w = 8'd1; h = 7'd1; color = 3'd3; go = 1'b1;
    step();
    check("held_pix1", obs_all(), {11'd0, 3'b110, 8'd1, 7'd2, 3'd3});
    step();
    check("held_done1", obs_ctl(), 32'b001);
    step();
    check("held_idle", obs_ctl(), 32'b000);
    step();
    check("held_pix2", obs_all(), {11'd0, 3'b110, 8'd1, 7'd2, 3'd3});
    go = 1'b0;
    step();
    check("held_done2", obs_ctl(), 32'b001);
    step();
    check("held_idle2", obs_ctl(), 32'b000);

    for (int k = 0; k < 12; k++) begin
      rx = $urandom_range(255, 0);
      ry = $urandom_range(127, 0);
      rw = ($urandom_range(4, 0) == 0) ? 0 : $urandom_range(12, 1);
      rh = ($urandom_range(4, 0) == 0) ? 0 : $urandom_range(8, 1);
      if (k % 3 == 0) begin
        rx = $urandom_range(159, 140);
        ry = $urandom_range(119, 105);
      end
      run_fill(1'b0, 8'(rx), 7'(ry), 8'(rw), 7'(rh), 3'($urandom), -1, -1);
    end

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
